// File: rtl/frame_centroid_pkg.sv
// Shared types, widths and helpers for the colour-blob centroid tracker.
// Accumulators saturate so that a pathological frame cannot wrap into a small centroid.
package centroid_pkg;

  localparam int ACC_W     = 32;
  localparam int CNT_W     = 21;
  localparam int DIV_ITERS = 32;

  typedef enum logic {
    ACCUM  = 1'b0,
    DIVIDE = 1'b1
  } state_t;

  function automatic logic [ACC_W-1:0] satAdd(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/frame_centroid_if.sv
// Pixel stream, thresholds, frame strobe and centroid results of the tracker.
interface frame_centroid_if #(
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10
);

  logic                    pixel_valid_in;
  logic [HCOUNT_WIDTH-1:0] pixel_hcount_in;
  logic [VCOUNT_WIDTH-1:0] pixel_vcount_in;
  logic [15:0]             pixel_data_in;
  logic [4:0]              r_min_in;
  logic [5:0]              g_max_in;
  logic [4:0]              b_max_in;
  logic                    tabulate_in;
  logic [HCOUNT_WIDTH-1:0] x_out;
  logic [VCOUNT_WIDTH-1:0] y_out;
  logic                    valid_out;
  logic                    busy_out;
  logic                    overrun_out;

  modport master (
    output pixel_valid_in, pixel_hcount_in, pixel_vcount_in, pixel_data_in,
    output r_min_in, g_max_in, b_max_in, tabulate_in,
    input  x_out, y_out, valid_out, busy_out, overrun_out
  );

  modport slave (
    input  pixel_valid_in, pixel_hcount_in, pixel_vcount_in, pixel_data_in,
    input  r_min_in, g_max_in, b_max_in, tabulate_in,
    output x_out, y_out, valid_out, busy_out, overrun_out
  );

endinterface

// File: rtl/frame_centroid_divider32.sv
// Sequential restoring 32-bit unsigned divider: one quotient bit per cycle,
// done pulses in the cycle the last bit is available on quotient_o.
module divider32
  import centroid_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [ACC_W-1:0] dividend_i,
  input  logic [ACC_W-1:0] divisor_i,
  output logic [OUT_W-1:0] quotient_o,
  output logic             done_o
);

  localparam int ITER_W = $clog2(DIV_ITERS + 1);

  logic [ACC_W-1:0]  rem_q;
  logic [ACC_W-1:0]  quo_q;
  logic [ACC_W-1:0]  div_q;
  logic [ITER_W-1:0] iter_q;
  logic              done_q;
  logic [ACC_W:0]    shifted;
  logic [ACC_W:0]    diff;

  // Remainder stays below the divisor, so bit ACC_W of diff is a clean borrow flag.
  always_comb begin
    shifted = {rem_q, quo_q[ACC_W-1]};
    diff    = shifted - {1'b0, div_q};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      iter_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= '0;
        quo_q  <= dividend_i;
        div_q  <= divisor_i;
        iter_q <= ITER_W'(DIV_ITERS);
      end else if (iter_q != '0) begin
        if (!diff[ACC_W]) begin
          rem_q <= diff[ACC_W-1:0];
          quo_q <= {quo_q[ACC_W-2:0], 1'b1};
        end else begin
          rem_q <= shifted[ACC_W-1:0];
          quo_q <= {quo_q[ACC_W-2:0], 1'b0};
        end
        iter_q <= iter_q - 1'b1;
        if (iter_q == ITER_W'(1)) done_q <= 1'b1;
      end
    end
  end

  assign quotient_o = quo_q[OUT_W-1:0];
  assign done_o     = done_q;

endmodule

// File: rtl/frame_centroid.sv
// Accumulates coordinates of colour-thresholded pixels over a frame and divides
// them out at the frame strobe, while the next frame keeps accumulating.
module frame_centroid
  import centroid_pkg::*;
#(
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10
) (
  input  logic            clk_in,
  input  logic            rst_in,
  frame_centroid_if.slave bus
);

  state_t                  state_q;
  logic [ACC_W-1:0]        sumX_q, sumX_d, sumY_q, sumY_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ACC_W-1:0]        accX, accY;
  logic [CNT_W-1:0]        accCnt;
  logic                    pixSel;
  logic                    startDiv;
  logic [HCOUNT_WIDTH-1:0] quoX, xOut_q;
  logic [VCOUNT_WIDTH-1:0] quoY, yOut_q;
  logic                    doneX, doneY;
  logic                    valid_q, busy_q, overrun_q;

  // A pixel arriving with the frame strobe is folded in before the snapshot.
  always_comb begin
    pixSel = bus.pixel_valid_in
          && (bus.pixel_data_in[15:11] >= bus.r_min_in)
          && (bus.pixel_data_in[10:5]  <= bus.g_max_in)
          && (bus.pixel_data_in[4:0]   <= bus.b_max_in);
    accX   = sumX_q;
    accY   = sumY_q;
    accCnt = count_q;
    if (pixSel) begin
      accX   = satAdd(sumX_q, ACC_W'(bus.pixel_hcount_in));
      accY   = satAdd(sumY_q, ACC_W'(bus.pixel_vcount_in));
      accCnt = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    end
    startDiv = (state_q == ACCUM) && bus.tabulate_in && (accCnt != '0);
    sumX_d   = bus.tabulate_in ? '0 : accX;
    sumY_d   = bus.tabulate_in ? '0 : accY;
    count_d  = bus.tabulate_in ? '0 : accCnt;
  end

  divider32 #(.OUT_W(HCOUNT_WIDTH)) divX (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .start_i    (startDiv),
    .dividend_i (accX),
    .divisor_i  (ACC_W'(accCnt)),
    .quotient_o (quoX),
    .done_o     (doneX)
  );

  divider32 #(.OUT_W(VCOUNT_WIDTH)) divY (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .start_i    (startDiv),
    .dividend_i (accY),
    .divisor_i  (ACC_W'(accCnt)),
    .quotient_o (quoY),
    .done_o     (doneY)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ACCUM;
      sumX_q    <= '0;
      sumY_q    <= '0;
      count_q   <= '0;
      xOut_q    <= '0;
      yOut_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sumX_q    <= sumX_d;
      sumY_q    <= sumY_d;
      count_q   <= count_d;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (startDiv) begin
            state_q <= DIVIDE;
            busy_q  <= 1'b1;
          end
        end
        DIVIDE: begin
          // A strobe here drops the frame just closed; the running division is kept.
          if (bus.tabulate_in) overrun_q <= 1'b1;
          if (doneX && doneY) begin
            xOut_q  <= quoX;
            yOut_q  <= quoY;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_out       = xOut_q;
  assign bus.y_out       = yOut_q;
  assign bus.valid_out   = valid_q;
  assign bus.busy_out    = busy_q;
  assign bus.overrun_out = overrun_q;

endmodule

// File: tb/tb_frame_centroid.sv
// Directed bench for frame_centroid: a pixel model pushes expected centroids and
// their due cycle into a scoreboard that is checked against the DUT every cycle.
module tb_frame_centroid;

  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] R_FOUR = 16'h2000;
  localparam logic [15:0] BOUND  = {5'd16, 6'd20, 5'd10};
  localparam logic [15:0] R_LOW  = {5'd15, 6'd0, 5'd0};
  localparam logic [15:0] G_HIGH = {5'd31, 6'd21, 5'd0};
  localparam logic [15:0] B_HIGH = {5'd31, 6'd0, 5'd11};

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    int          cyc;
  } exp_t;

  logic  clk_in;
  logic  rst_in;
  exp_t  sb[$];
  exp_t  cur;
  int    vectors;
  int    miscompares;
  int    cyc;
  int    expOvCyc;
  int    t0;
  longint mSx, mSy, mCnt;
  logic [10:0] mX;
  logic [9:0]  mY;

  frame_centroid_if #(.HCOUNT_WIDTH(11), .VCOUNT_WIDTH(10)) bus ();

  frame_centroid #(.HCOUNT_WIDTH(11), .VCOUNT_WIDTH(10)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Advance one cycle, then compare every output against the model.
  task automatic tick();
    bit expValid;
    @(posedge clk_in);
    #1;
    cyc++;
    expValid = (sb.size() != 0) && (sb[0].cyc == cyc);
    checkOutput("valid_out", 32'(bus.valid_out), 32'(expValid));
    if (expValid) begin
      cur = sb.pop_front();
      mX  = cur.x;
      mY  = cur.y;
    end
    checkOutput("x_out", 32'(bus.x_out), 32'(mX));
    checkOutput("y_out", 32'(bus.y_out), 32'(mY));
    checkOutput("busy_out", 32'(bus.busy_out), 32'(sb.size() != 0));
    checkOutput("overrun_out", 32'(bus.overrun_out), 32'(cyc == expOvCyc));
  endtask

  task automatic applyStimulus(input bit pv, input int h, input int v,
                               input logic [15:0] rgb, input bit tab);
    exp_t e;
    if (pv && (rgb[15:11] >= bus.r_min_in) && (rgb[10:5] <= bus.g_max_in)
           && (rgb[4:0] <= bus.b_max_in)) begin
      mSx  += h;
      mSy  += v;
      mCnt += 1;
    end
    if (tab) begin
      if (sb.size() != 0) begin
        expOvCyc = cyc + 1;
      end else if (mCnt != 0) begin
        e.x   = 11'(mSx / mCnt);
        e.y   = 10'(mSy / mCnt);
        e.cyc = cyc + 34;
        sb.push_back(e);
      end
      mSx = 0; mSy = 0; mCnt = 0;
    end
    bus.pixel_valid_in  = pv;
    bus.pixel_hcount_in = 11'(h);
    bus.pixel_vcount_in = 10'(v);
    bus.pixel_data_in   = rgb;
    bus.tabulate_in     = tab;
    tick();
    bus.pixel_valid_in  = 1'b0;
    bus.tabulate_in     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_x_out", 32'(bus.x_out), 32'd0);
    checkOutput("rst_y_out", 32'(bus.y_out), 32'd0);
    checkOutput("rst_valid_out", 32'(bus.valid_out), 32'd0);
    checkOutput("rst_busy_out", 32'(bus.busy_out), 32'd0);
    checkOutput("rst_overrun_out", 32'(bus.overrun_out), 32'd0);
  endtask

  // Asynchronous assertion mid-cycle; outputs must clear before any clock edge.
  task automatic doReset();
    #2 rst_in = 1'b1;
    #1;
    checkResetOutputs();
    sb.delete();
    mX = '0; mY = '0;
    mSx = 0; mSy = 0; mCnt = 0;
    expOvCyc = -1;
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; expOvCyc = -1;
    mSx = 0; mSy = 0; mCnt = 0; mX = '0; mY = '0;
    clk_in = 1'b0;
    rst_in = 1'b1;
    bus.pixel_valid_in = 1'b0; bus.pixel_hcount_in = '0; bus.pixel_vcount_in = '0;
    bus.pixel_data_in = '0; bus.tabulate_in = 1'b0;
    bus.r_min_in = 5'd16; bus.g_max_in = 6'd20; bus.b_max_in = 5'd10;
    #3;
    checkResetOutputs();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    // Two red pixels: centroid (20,30) exactly 34 cycles after the strobe.
    applyStimulus(1, 10, 20, RED, 0);
    idle(2);
    applyStimulus(1, 30, 40, RED, 0);
    applyStimulus(0, 0, 0, '0, 1);
    idle(36);

    // Floor division, last pixel on the strobe cycle belongs to this frame.
    applyStimulus(1, 1, 0, RED, 0);
    applyStimulus(1, 2, 0, RED, 0);
    applyStimulus(1, 2, 1, RED, 1);
    idle(36);

    // R=4 rejected with r_min 5, (100,50) accepted.
    bus.r_min_in = 5'd5;
    applyStimulus(1, 7, 7, R_FOUR, 0);
    applyStimulus(1, 100, 50, RED, 0);
    applyStimulus(0, 0, 0, '0, 1);
    idle(36);

    // Threshold boundaries: equal passes, one step beyond fails, strobe-less ignored.
    bus.r_min_in = 5'd16;
    applyStimulus(1, 200, 150, BOUND, 0);
    applyStimulus(1, 900, 900, R_LOW, 0);
    applyStimulus(1, 900, 900, G_HIGH, 0);
    applyStimulus(1, 900, 900, B_HIGH, 0);
    applyStimulus(0, 900, 900, RED, 0);
    applyStimulus(1, 100, 50, RED, 1);
    idle(36);

    // Empty frames: no result, outputs hold.
    applyStimulus(0, 0, 0, '0, 1);
    idle(40);
    applyStimulus(1, 5, 5, R_LOW, 1);
    idle(40);

    // Overrun at T+10, then a new frame started on the return cycle T+34.
    t0 = cyc;
    applyStimulus(1, 40, 60, RED, 0);
    t0 = cyc;
    applyStimulus(1, 60, 80, RED, 1);
    tick();
    applyStimulus(1, 500, 500, RED, 0);
    while (cyc < t0 + 10) tick();
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(1, 8, 4, RED, 0);
    applyStimulus(1, 12, 6, RED, 0);
    while (cyc < t0 + 34) tick();
    applyStimulus(0, 0, 0, '0, 1);
    idle(36);

    // Reset mid-division aborts it; the first frame afterwards is normal.
    t0 = cyc;
    applyStimulus(1, 2, 2, RED, 1);
    while (cyc < t0 + 15) tick();
    doReset();
    idle(40);
    applyStimulus(1, 6, 9, RED, 1);
    idle(36);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
